// File: rtl/matrix_pkg.sv
// Shared constants, state encoding and helpers for the packed 5x5 int8 matrix datapath.
package matrix_pkg;

  localparam int DIM    = 5;
  localparam int ELEM_W = 8;
  localparam int MAT_W  = DIM * DIM * ELEM_W;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_e;

  // Bit offset of elem(i,j) inside a packed matrix, row-major.
  function automatic int elem_off(input int i, input int j, input int dim, input int ew);
    return (i * dim + j) * ew;
  endfunction

  // Out-of-range sizes (0, >DIM) fall back to the full matrix.
  function automatic logic [2:0] clamp_size(input logic [2:0] s);
    if (s == 3'd0 || int'(s) > DIM) return 3'(DIM);
    return s;
  endfunction

endpackage

// File: rtl/result_serializer_if.sv
// Valid/ready beat stream from result_serializer to the HPS bridge.
// With RESULT_PARITY_EN defined the stream carries an even-parity bit.
interface result_serializer_if #(
  parameter int ELEM_W = matrix_pkg::ELEM_W
);
  logic              out_valid;
  logic              out_ready;
  logic [ELEM_W-1:0] out_data;
  logic [2:0]        out_row;
  logic [2:0]        out_col;
  logic              out_last;
`ifdef RESULT_PARITY_EN
  logic              out_parity;
`endif

  modport master (
    output out_valid, out_data, out_row, out_col, out_last,
`ifdef RESULT_PARITY_EN
    output out_parity,
`endif
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_row, out_col, out_last,
`ifdef RESULT_PARITY_EN
    input  out_parity,
`endif
    output out_ready
  );
endinterface

// File: rtl/result_elem_mux.sv
// Combinational DIM*DIM:1 element selector (matrix, row, col) -> element.
// Shared with the operand loader, so it carries its own size parameters.
module result_elem_mux
  import matrix_pkg::*;
#(
  parameter int P_DIM    = DIM,
  parameter int P_ELEM_W = ELEM_W
) (
  input  logic [P_DIM*P_DIM*P_ELEM_W-1:0] mat_i,
  input  logic [2:0]                      row_i,
  input  logic [2:0]                      col_i,
  output logic [P_ELEM_W-1:0]             elem_o
);
  localparam int N_ELEM = P_DIM * P_DIM;
  localparam int IDX_W  = $clog2(N_ELEM);

  logic [P_ELEM_W-1:0] elems [N_ELEM];
  logic [IDX_W-1:0]    idx;

  for (genvar i = 0; i < P_DIM; i++) begin : g_row
    for (genvar j = 0; j < P_DIM; j++) begin : g_col
      assign elems[i*P_DIM+j] = mat_i[elem_off(i, j, P_DIM, P_ELEM_W) +: P_ELEM_W];
    end
  end

  always_comb begin
    idx    = IDX_W'(row_i) * IDX_W'(P_DIM) + IDX_W'(col_i);
    elem_o = '0;
    if (int'(idx) < N_ELEM) elem_o = elems[idx];
  end
endmodule

// File: rtl/result_serializer.sv
// Captures a packed result matrix on load and streams its NxN top-left submatrix row-major.
// RESULT_PARITY_EN adds out_parity (even parity of out_data) to the stream interface.
module result_serializer
  import matrix_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic [MAT_W-1:0]          matrix_in,
  input  logic                      ovf_in,
  input  logic [2:0]                size_in,
  result_serializer_if.master       out_if,
  output logic                      ovf_out,
  output logic                      busy,
  output logic                      done
);
  ser_state_e       state_q, state_d;
  logic [MAT_W-1:0] mat_q, mat_d;
  logic [2:0]       size_q, size_d;
  logic [2:0]       row_q, row_d;
  logic [2:0]       col_q, col_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [ELEM_W-1:0] elem;
  logic              sending, last_col, last_beat, hs, last_hs, accept;

  assign sending   = (state_q == SEND);
  assign last_col  = (col_q == size_q - 3'd1);
  assign last_beat = sending && last_col && (row_q == size_q - 3'd1);
  assign hs        = sending && out_if.out_ready;
  assign last_hs   = hs && last_beat;
  // A load on the final handshake chains straight into the next matrix.
  assign accept    = load && (!sending || last_hs);

  result_elem_mux #(.P_DIM(DIM), .P_ELEM_W(ELEM_W)) u_mux (
    .mat_i  (mat_q),
    .row_i  (row_q),
    .col_i  (col_q),
    .elem_o (elem)
  );

  always_comb begin
    state_d = state_q;
    mat_d   = mat_q;
    size_d  = size_q;
    row_d   = row_q;
    col_d   = col_q;
    ovf_d   = ovf_q;
    done_d  = last_hs;
    if (accept) begin
      state_d = SEND;
      mat_d   = matrix_in;
      size_d  = clamp_size(size_in);
      ovf_d   = ovf_in;
      row_d   = '0;
      col_d   = '0;
    end else if (hs) begin
      if (last_beat) begin
        state_d = IDLE;
        row_d   = '0;
        col_d   = '0;
      end else if (last_col) begin
        col_d = '0;
        row_d = row_q + 3'd1;
      end else begin
        col_d = col_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mat_q   <= '0;
      size_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mat_q   <= mat_d;
      size_q  <= size_d;
      row_q   <= row_d;
      col_q   <= col_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign out_if.out_valid = sending;
  assign out_if.out_data  = sending ? elem : '0;
  assign out_if.out_row   = row_q;
  assign out_if.out_col   = col_q;
  assign out_if.out_last  = last_beat;
`ifdef RESULT_PARITY_EN
  assign out_if.out_parity = sending ? ^elem : 1'b0;
`endif

  assign ovf_out = ovf_q;
  assign busy    = sending;
  assign done    = done_q;
endmodule

// File: tb/tb_result_serializer.sv
// Self-checking bench for result_serializer: table vectors, hand corner sequences, random streams.
module tb_result_serializer;
  import matrix_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             load = 1'b0;
  logic [MAT_W-1:0] matrix_in = '0;
  logic             ovf_in = 1'b0;
  logic [2:0]       size_in = 3'd0;
  logic             ovf_out, busy, done;

  int errors = 0;
  int checks = 0;

  result_serializer_if sif ();

  result_serializer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .matrix_in (matrix_in),
    .ovf_in    (ovf_in),
    .size_in   (size_in),
    .out_if    (sif),
    .ovf_out   (ovf_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] size;
    int         exp_n;
    logic       ovf;
    int         pat;
    int         stall;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [MAT_W-1:0] make_mat(input int pat);
    logic [MAT_W-1:0] m;
    m = '0;
    for (int k = 0; k < DIM*DIM; k++) begin
      case (pat)
        0:       m[k*ELEM_W +: ELEM_W] = 8'(k);
        3:       m[k*ELEM_W +: ELEM_W] = 8'h07;
        4:       m[k*ELEM_W +: ELEM_W] = 8'hFF;
        default: m[k*ELEM_W +: ELEM_W] = 8'($urandom_range(255));
      endcase
    end
    if (pat == 1) m[(1*DIM+1)*ELEM_W +: ELEM_W] = 8'h80;
    return m;
  endfunction

  task automatic do_load(input logic [MAT_W-1:0] m, input logic [2:0] s, input logic o);
    load = 1'b1; matrix_in = m; size_in = s; ovf_in = o;
    @(posedge clk); @(negedge clk);
    load = 1'b0;
  endtask

  // Expected beat k of an NxN stream is elem(k/N, k%N); the bench walks k on each handshake.
  task automatic stream(input logic [MAT_W-1:0] m, input int n, input logic o, input int stall_pct,
                        input bit chain, input logic [MAT_W-1:0] m2, input logic [2:0] s2,
                        input logic o2);
    int idx = 0;
    int cyc = 0;
    int r, c;
    logic [7:0] ed;
    bit rdy;
    while (idx < n*n && cyc < 4000) begin
      r  = idx / n;
      c  = idx % n;
      ed = m[(r*DIM+c)*ELEM_W +: ELEM_W];
      chk("out_valid", 32'(sif.out_valid), 32'd1);
      chk("out_data", 32'(sif.out_data), 32'(ed));
      chk("out_row", 32'(sif.out_row), 32'(r));
      chk("out_col", 32'(sif.out_col), 32'(c));
      chk("out_last", 32'(sif.out_last), 32'(idx == n*n-1));
      chk("busy", 32'(busy), 32'd1);
      chk("ovf_out", 32'(ovf_out), 32'(o));
`ifdef RESULT_PARITY_EN
      chk("out_parity", 32'(sif.out_parity), 32'(^ed));
`endif
      rdy = ($urandom_range(99) >= 32'(stall_pct));
      sif.out_ready = rdy;
      if (chain && rdy && idx == n*n-1) begin
        load = 1'b1; matrix_in = m2; size_in = s2; ovf_in = o2;
      end
      @(posedge clk); @(negedge clk);
      load = 1'b0;
      cyc++;
      if (rdy) idx++;
    end
    sif.out_ready = 1'b0;
    chk("beat_budget", 32'(cyc < 4000), 32'd1);
    chk("done_pulse", 32'(done), 32'd1);
    chk("valid_after_last", 32'(sif.out_valid), 32'(chain));
    chk("busy_after_last", 32'(busy), 32'(chain));
    if (!chain) begin
      @(negedge clk);
      chk("done_falls", 32'(done), 32'd0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(sif.out_valid), 32'd0);
    chk({tag, "_data"}, 32'(sif.out_data), 32'd0);
    chk({tag, "_row"}, 32'(sif.out_row), 32'd0);
    chk({tag, "_col"}, 32'(sif.out_col), 32'd0);
    chk({tag, "_last"}, 32'(sif.out_last), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_ovf"}, 32'(ovf_out), 32'd0);
`ifdef RESULT_PARITY_EN
    chk({tag, "_parity"}, 32'(sif.out_parity), 32'd0);
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[8];
    logic [MAT_W-1:0] m, m2;
    logic [2:0] s;
    logic o;
    int n;

    tbl[0] = '{3'd5, 5, 1'b0, 0, 0};
    tbl[1] = '{3'd2, 2, 1'b1, 1, 0};
    tbl[2] = '{3'd3, 3, 1'b0, 2, 50};
    tbl[3] = '{3'd1, 1, 1'b1, 2, 0};
    tbl[4] = '{3'd0, 5, 1'b0, 2, 30};
    tbl[5] = '{3'd7, 5, 1'b1, 3, 0};
    tbl[6] = '{3'd6, 5, 1'b0, 2, 20};
    tbl[7] = '{3'd4, 4, 1'b1, 2, 60};

    sif.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("idle");

    for (int k = 0; k < 8; k++) begin
      m = make_mat(tbl[k].pat);
      do_load(m, tbl[k].size, tbl[k].ovf);
      stream(m, tbl[k].exp_n, tbl[k].ovf, tbl[k].stall, 1'b0, '0, 3'd0, 1'b0);
    end

    // Load while mid-stream is ignored.
    m  = make_mat(2);
    m2 = make_mat(2);
    do_load(m, 3'd3, 1'b1);
    sif.out_ready = 1'b0;
    load = 1'b1; matrix_in = m2; size_in = 3'd5; ovf_in = 1'b0;
    @(posedge clk); @(negedge clk);
    load = 1'b0;
    stream(m, 3, 1'b1, 40, 1'b0, '0, 3'd0, 1'b0);

    // Load on the last handshake chains without an IDLE cycle.
    m  = make_mat(2);
    m2 = make_mat(4);
    do_load(m, 3'd2, 1'b0);
    stream(m, 2, 1'b0, 0, 1'b1, m2, 3'd5, 1'b1);
    stream(m2, 5, 1'b1, 25, 1'b0, '0, 3'd0, 1'b0);

    // Async reset during the third beat.
    m = make_mat(0);
    do_load(m, 3'd5, 1'b1);
    sif.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("third_beat_data", 32'(sif.out_data), 32'd2);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    sif.out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("post_reset");

    for (int it = 0; it < 12; it++) begin
      s = 3'($urandom_range(7));
      o = 1'($urandom_range(1));
      n = (s == 3'd0 || s > 3'd5) ? 5 : int'(s);
      m = make_mat(2);
      repeat ($urandom_range(2)) @(negedge clk);
      do_load(m, s, o);
      stream(m, n, o, int'($urandom_range(70)), 1'b0, '0, 3'd0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
